// File: rtl/program_loader.sv
// Program loader: accepts a byte stream from a host and writes it into the CPU RAM
// over the shared bus, holding the CPU while the load is in progress.
module program_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [7:0]        bus_o,
  output logic              bus_oe,
  output logic              mi,
  output logic              ri,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SET_ADDR  = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic              in_ready_q;
  logic [7:0]        bus_o_q;
  logic              bus_oe_q;
  logic              mi_q;
  logic              ri_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;

  // Abort wins over everything once a load is underway; IDLE ignores it entirely.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d  = '0;
            state_d = WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (in_valid) begin
            data_d  = in_data;
            state_d = SET_ADDR;
          end
        end
        SET_ADDR: state_d = WRITE;
        WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = WAIT_BYTE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      bus_o_q    <= '0;
      bus_oe_q   <= 1'b0;
      mi_q       <= 1'b0;
      ri_q       <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= (state_d == WAIT_BYTE);
      bus_oe_q   <= (state_d == SET_ADDR) || (state_d == WRITE);
      mi_q       <= (state_d == SET_ADDR);
      ri_q       <= (state_d == WRITE);
      cpu_hold_q <= (state_d != IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      if (state_d == SET_ADDR) begin
        bus_o_q <= 8'(addr_d);
      end else if (state_d == WRITE) begin
        bus_o_q <= data_d;
      end else begin
        bus_o_q <= '0;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign bus_o    = bus_o_q;
  assign bus_oe   = bus_oe_q;
  assign mi       = mi_q;
  assign ri       = ri_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign addr     = addr_q;

  // Bus strobes must never collide or fire without the bus being driven.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!clr) !(mi_q && ri_q));
  a_strobe_oe:   assert property (@(posedge clk) disable iff (!clr) !((mi_q || ri_q) && !bus_oe_q));
  a_bus_quiet:   assert property (@(posedge clk) disable iff (!clr) bus_oe_q || (bus_o_q == 8'd0));

endmodule
